// File: rtl/dp_mem_initiator_pkg.sv
// Shared types, default widths and wrap-address helper for the dp_mem initiator.
// VERIFY state is present only when DP_INIT_VERIFY_EN is defined.
package dp_mem_pkg;

  localparam int ADDR_W_DEF    = 5;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
`ifdef DP_INIT_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  typedef struct packed {
    logic vld;
    logic last;
    logic vfy;
  } rd_tag_t;

  // Increment the in-bank offset only; the bank MSB and anything above it are preserved.
  function automatic logic [31:0] inc_in_bank(input logic [31:0] addr, input int addr_w);
    logic [31:0] low;
    low = (32'd1 << (addr_w - 1)) - 32'd1;
    return (addr & ~low) | ((addr + 32'd1) & low);
  endfunction

endpackage

// File: rtl/dp_mem_initiator_if.sv
// Host command/write/read-return channels plus memory-port strobes of the initiator.
// master: the initiator itself; slave: host and memory environment.
interface dp_mem_initiator_if
  import dp_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_burst;
  logic [ADDR_W-1:0] cmd_addr;
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              vfy_err;
  logic              mem_enb;
  logic              mem_wr;
  logic              mem_rd;
  logic              mem_burst;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_burst, cmd_addr, wd_valid, wd_data, mem_r_data,
    output cmd_ready, wd_ready, rd_valid, rd_data, rd_last, busy, vfy_err,
    output mem_enb, mem_wr, mem_rd, mem_burst, mem_w_addr, mem_r_addr, mem_w_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_burst, cmd_addr, wd_valid, wd_data, mem_r_data,
    input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last, busy, vfy_err,
    input  mem_enb, mem_wr, mem_rd, mem_burst, mem_w_addr, mem_r_addr, mem_w_data
  );
endinterface

// File: rtl/dp_mem_rd_pipe.sv
// RD_LAT-stage shift line of read tags; the output tag lines up with valid mem_r_data.
// Latency RD_LAT cycles from the issued tag; no backpressure.
module dp_mem_rd_pipe
  import dp_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t issue_tag,
  output rd_tag_t ret_tag
);

  rd_tag_t [RD_LAT-1:0] line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line <= '0;
    end else begin
      line[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign ret_tag = line[RD_LAT-1];

endmodule

// File: rtl/dp_mem_initiator.sv
// Sequences single/burst read/write commands onto the banked memory port (DP_INIT_VERIFY_EN adds write readback).
// Registered mem_* strobes one cycle after acceptance; reads return RD_LAT+1 after issue; writes stall on wd_valid.
module dp_mem_initiator
  import dp_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int RD_LAT    = 1
) (
  input logic               clk,
  input logic               rst,
  dp_mem_initiator_if.master bus
);

  localparam int              CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, iss_addr;
  logic [CNT_W-1:0]  left_q, cmd_beats;
  logic              burst_q;
  logic              load_cmd, do_wr, do_rd, iss_last, iss_vfy;
  logic              cmd_ready, wd_ready;

  logic              mem_enb_q, mem_wr_q, mem_rd_q, mem_burst_q;
  logic [ADDR_W-1:0] mem_w_addr_q, mem_r_addr_q;
  logic [DATA_W-1:0] mem_w_data_q, rd_data_q;
  logic              rd_valid_q, rd_last_q, iss_last_q, iss_vfy_q;
  rd_tag_t           issue_tag, ret_tag;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(inc_in_bank(32'(a), ADDR_W));
  endfunction

  assign cmd_beats = bus.cmd_burst ? CNT_W'(BURST_LEN) : ONE;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    load_cmd  = 1'b0;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    iss_last  = 1'b0;
    iss_vfy   = 1'b0;
    iss_addr  = addr_q;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          load_cmd = 1'b1;
          if (bus.cmd_write) begin
            state_nxt = WRITE;
          end else begin
            // First read beat issues on the accepting edge itself.
            do_rd     = 1'b1;
            iss_addr  = bus.cmd_addr;
            iss_last  = !bus.cmd_burst;
            state_nxt = bus.cmd_burst ? READ : DRAIN;
          end
        end
      end
      WRITE: begin
        wd_ready = 1'b1;
        if (bus.wd_valid) begin
          do_wr = 1'b1;
          if (left_q == ONE) begin
`ifdef DP_INIT_VERIFY_EN
            state_nxt = VERIFY;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
      READ: begin
        do_rd    = 1'b1;
        iss_last = (left_q == ONE);
        if (left_q == ONE) state_nxt = DRAIN;
      end
`ifdef DP_INIT_VERIFY_EN
      VERIFY: begin
        do_rd    = 1'b1;
        iss_vfy  = 1'b1;
        iss_last = (left_q == ONE);
        if (left_q == ONE) state_nxt = DRAIN;
      end
`endif
      DRAIN: begin
        if (ret_tag.vld && ret_tag.last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DP_INIT_VERIFY_EN
  localparam int IDX_W = $clog2(BURST_LEN);

  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wbuf [BURST_LEN];
  logic [IDX_W-1:0]  wr_idx, cmp_idx;
  logic              vfy_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      wr_idx    <= '0;
      cmp_idx   <= '0;
      vfy_err_q <= 1'b0;
    end else begin
      if (load_cmd) begin
        base_q    <= bus.cmd_addr;
        wr_idx    <= '0;
        cmp_idx   <= '0;
        vfy_err_q <= 1'b0;
      end
      if (do_wr) wr_idx <= wr_idx + 1'b1;
      if (ret_tag.vld && ret_tag.vfy) begin
        cmp_idx <= cmp_idx + 1'b1;
        if (bus.mem_r_data != wbuf[cmp_idx]) vfy_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) wbuf[wr_idx] <= bus.wd_data;
  end

  assign bus.vfy_err = vfy_err_q;
`else
  assign bus.vfy_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      left_q       <= '0;
      burst_q      <= 1'b0;
      mem_enb_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_burst_q  <= 1'b0;
      mem_w_addr_q <= '0;
      mem_r_addr_q <= '0;
      mem_w_data_q <= '0;
      iss_last_q   <= 1'b0;
      iss_vfy_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state       <= state_nxt;
      mem_enb_q   <= (state_nxt != IDLE);
      mem_wr_q    <= do_wr;
      mem_rd_q    <= do_rd;
      mem_burst_q <= (do_wr || do_rd) && (load_cmd ? bus.cmd_burst : burst_q);
      iss_last_q  <= iss_last;
      iss_vfy_q   <= iss_vfy;
      if (load_cmd) begin
        burst_q <= bus.cmd_burst;
        addr_q  <= bus.cmd_addr;
        left_q  <= bus.cmd_write ? cmd_beats : cmd_beats - ONE;
      end
      if (do_wr) begin
        mem_w_addr_q <= addr_q;
        mem_w_data_q <= bus.wd_data;
        addr_q       <= next_addr(addr_q);
        left_q       <= left_q - ONE;
      end
      if (do_rd) begin
        mem_r_addr_q <= iss_addr;
        addr_q       <= next_addr(iss_addr);
        if (!load_cmd) left_q <= left_q - ONE;
      end
`ifdef DP_INIT_VERIFY_EN
      // Rewind to the command's start address for the readback pass.
      if (state == WRITE && state_nxt == VERIFY) begin
        addr_q <= base_q;
        left_q <= burst_q ? CNT_W'(BURST_LEN) : ONE;
      end
`endif
      rd_valid_q <= ret_tag.vld && !ret_tag.vfy;
      rd_last_q  <= ret_tag.vld && ret_tag.last && !ret_tag.vfy;
      if (ret_tag.vld && !ret_tag.vfy) rd_data_q <= bus.mem_r_data;
    end
  end

  assign issue_tag = '{vld: mem_rd_q, last: iss_last_q, vfy: iss_vfy_q};

  dp_mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue_tag (issue_tag),
    .ret_tag   (ret_tag)
  );

  assign bus.cmd_ready  = cmd_ready;
  assign bus.wd_ready   = wd_ready;
  assign bus.busy       = (state != IDLE);
  assign bus.mem_enb    = mem_enb_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_burst  = mem_burst_q;
  assign bus.mem_w_addr = mem_w_addr_q;
  assign bus.mem_r_addr = mem_r_addr_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_last    = rd_last_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_dp_mem_initiator.sv
// Bench for dp_mem_initiator: directed vector table, reset/verify sequences, random commands vs a memory model.
module tb_dp_mem_initiator;

  localparam int AW = 5, DW = 8, BL = 4, RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dp_mem_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  dp_mem_initiator #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory with one-cycle registered read; corrupt inverts returned data.
  bit [7:0] mem_arr [32];
  bit       corrupt;
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_r_data <= corrupt ? ~mem_arr[bus.mem_r_addr] : mem_arr[bus.mem_r_addr];
    if (bus.mem_wr) mem_arr[bus.mem_w_addr] <= bus.mem_w_data;
  end

  bit [7:0] ref_mem [32];
  int total = 0;
  int bad   = 0;

  typedef struct {
    bit              wr;
    bit              bst;
    logic [4:0]      a;
    logic [3:0][7:0] d;
    logic [3:0][4:0] ea;
    int              stall;
  } vec_t;

  int         obs_wn[$], obs_rn[$], obs_vn[$];
  logic [4:0] obs_wa[$], obs_ra[$];
  logic [7:0] obs_wd[$], obs_vd[$];
  bit         obs_wb[$], obs_rb[$], obs_vl[$];
  logic       end_vfy_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_addr(input logic [4:0] a, input int i);
    int bank, off;
    bank = int'(a) / 16;
    off  = (int'(a) % 16 + i) % 16;
    return 5'(bank * 16 + off);
  endfunction

  function automatic vec_t mk(input bit wr, input bit bst, input logic [4:0] a,
                              input logic [31:0] d, input logic [19:0] ea, input int st);
    vec_t v;
    v.wr = wr; v.bst = bst; v.a = a; v.stall = st;
    for (int i = 0; i < 4; i++) begin
      v.d[i]  = d[31-8*i -: 8];
      v.ea[i] = ea[19-5*i -: 5];
    end
    return v;
  endfunction

  // Issue one command, feed write beats, record every strobe with its cycle offset from acceptance.
  task automatic exec(input vec_t v);
    int n, beats, bi, stall_left;
    bit done, stalled;
    obs_wn.delete(); obs_wa.delete(); obs_wd.delete(); obs_wb.delete();
    obs_rn.delete(); obs_ra.delete(); obs_rb.delete();
    obs_vn.delete(); obs_vd.delete(); obs_vl.delete();
    beats = v.bst ? BL : 1;
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_write = v.wr; bus.cmd_burst = v.bst; bus.cmd_addr = v.a;
    @(posedge clk);
    n = 0; bi = 0; stall_left = 0; done = 1'b0; stalled = 1'b0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      bus.cmd_valid = 1'b0;
      if (n == 1) begin
        chk("busy_after_accept", bus.busy, 1);
        chk("cmd_ready_busy", bus.cmd_ready, 0);
        chk("mem_enb_busy", bus.mem_enb, 1);
        chk("wd_ready_state", bus.wd_ready, v.wr);
        chk("vfy_err_cleared", bus.vfy_err, 0);
      end
      if (bus.mem_wr) begin obs_wn.push_back(n); obs_wa.push_back(bus.mem_w_addr); obs_wd.push_back(bus.mem_w_data); obs_wb.push_back(bus.mem_burst); end
      if (bus.mem_rd) begin obs_rn.push_back(n); obs_ra.push_back(bus.mem_r_addr); obs_rb.push_back(bus.mem_burst); end
      if (bus.rd_valid) begin obs_vn.push_back(n); obs_vd.push_back(bus.rd_data); obs_vl.push_back(bus.rd_last); end
      if (v.wr && v.stall == 2 && n == 5) begin
        chk("stall_wr_low", bus.mem_wr, 0);
        chk("stall_addr_hold", bus.mem_w_addr, ref_addr(v.a, 1));
      end
      if (n > 1 && !bus.busy) begin
        done = 1'b1;
        chk("cmd_ready_back", bus.cmd_ready, 1);
        end_vfy_err = bus.vfy_err;
      end
      if (done || !v.wr || bi >= beats) begin
        bus.wd_valid = 1'b0;
      end else if (stall_left > 0) begin
        bus.wd_valid = 1'b0;
        stall_left--;
      end else begin
        bus.wd_valid = 1'b1;
        bus.wd_data  = v.d[bi];
        if (bus.wd_ready) begin
          bi++;
          if (bi == v.stall && !stalled) begin stall_left = 3; stalled = 1'b1; end
        end
      end
    end
    chk("cmd_done_in_budget", done, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int beats;
    beats = v.bst ? BL : 1;
    exec(v);
    if (v.wr) begin
      chk("wr_count", obs_wa.size(), beats);
      for (int i = 0; i < beats && i < obs_wa.size(); i++) begin
        chk("wr_addr", obs_wa[i], v.ea[i]);
        chk("wr_data", obs_wd[i], v.d[i]);
        chk("wr_burst", obs_wb[i], v.bst);
        chk("wr_cycle", obs_wn[i], 2 + i + ((v.stall >= 0 && i >= v.stall) ? 3 : 0));
      end
      chk("wr_no_rd_valid", obs_vd.size(), 0);
`ifdef DP_INIT_VERIFY_EN
      chk("vfy_rd_count", obs_ra.size(), beats);
      chk("vfy_err_clean", end_vfy_err, 0);
`else
      chk("wr_no_mem_rd", obs_ra.size(), 0);
`endif
    end else begin
      chk("rd_issue_count", obs_ra.size(), beats);
      for (int i = 0; i < beats && i < obs_ra.size(); i++) begin
        chk("rd_addr", obs_ra[i], v.ea[i]);
        chk("rd_issue_cycle", obs_rn[i], 1 + i);
        chk("rd_burst", obs_rb[i], v.bst);
      end
      chk("rd_ret_count", obs_vd.size(), beats);
      for (int i = 0; i < beats && i < obs_vd.size(); i++) begin
        chk("rd_data", obs_vd[i], v.d[i]);
        chk("rd_last", obs_vl[i], (i == beats - 1));
        chk("rd_ret_cycle", obs_vn[i], 1 + i + RD_LAT + 1);
      end
    end
  endtask

  vec_t tbl [12];
  vec_t rv;
  int   hits;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_burst = 1'b0; bus.cmd_addr = '0;
    bus.wd_valid  = 1'b0; bus.wd_data   = '0;   corrupt = 1'b0;

    tbl[0]  = mk(1, 0, 5'h01, 32'hAA000000, {5'h01, 15'h0}, -1);
    tbl[1]  = mk(0, 0, 5'h01, 32'hAA000000, {5'h01, 15'h0}, -1);
    tbl[2]  = mk(1, 1, 5'h10, 32'hAABBCCDD, {5'h10, 5'h11, 5'h12, 5'h13}, -1);
    tbl[3]  = mk(0, 1, 5'h10, 32'hAABBCCDD, {5'h10, 5'h11, 5'h12, 5'h13}, -1);
    tbl[4]  = mk(1, 1, 5'h1E, 32'h11223344, {5'h1E, 5'h1F, 5'h10, 5'h11}, -1);
    tbl[5]  = mk(0, 1, 5'h1E, 32'h11223344, {5'h1E, 5'h1F, 5'h10, 5'h11}, -1);
    tbl[6]  = mk(1, 1, 5'h0E, 32'h55667788, {5'h0E, 5'h0F, 5'h00, 5'h01}, -1);
    tbl[7]  = mk(0, 1, 5'h0E, 32'h55667788, {5'h0E, 5'h0F, 5'h00, 5'h01}, -1);
    tbl[8]  = mk(0, 0, 5'h01, 32'h88000000, {5'h01, 15'h0}, -1);
    tbl[9]  = mk(0, 1, 5'h10, 32'h3344CCDD, {5'h10, 5'h11, 5'h12, 5'h13}, -1);
    tbl[10] = mk(1, 1, 5'h04, 32'hA1A2A3A4, {5'h04, 5'h05, 5'h06, 5'h07}, 2);
    tbl[11] = mk(0, 1, 5'h04, 32'hA1A2A3A4, {5'h04, 5'h05, 5'h06, 5'h07}, -1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_wd_ready", bus.wd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_strobes", {bus.mem_enb, bus.mem_wr, bus.mem_rd, bus.mem_burst}, 0);
    chk("rst_mem_addrs", {bus.mem_w_addr, bus.mem_r_addr, bus.mem_w_data}, 0);
    chk("rst_rd_out", {bus.rd_valid, bus.rd_last, bus.rd_data}, 0);
    chk("rst_vfy_err", bus.vfy_err, 0);
    rst = 1'b1;

    for (int t = 0; t < 12; t++) begin
      run_vec(tbl[t]);
      if (tbl[t].wr)
        for (int i = 0; i < (tbl[t].bst ? BL : 1); i++) ref_mem[tbl[t].ea[i]] = tbl[t].d[i];
    end

    // Reset during beat 2 of a burst read
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_burst = 1'b1; bus.cmd_addr = 5'h10;
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    chk("abort_pre_mem_rd", bus.mem_rd, 1);
    rst = 1'b0;
    #1;
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_mem_strobes", {bus.mem_enb, bus.mem_wr, bus.mem_rd, bus.mem_burst}, 0);
    chk("abort_mem_r_addr", bus.mem_r_addr, 0);
    chk("abort_rd_out", {bus.rd_valid, bus.rd_last, bus.rd_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rd_valid || bus.mem_rd || bus.busy) hits++;
    end
    chk("abort_no_stale", hits, 0);
    chk("abort_cmd_ready_after", bus.cmd_ready, 1);

`ifdef DP_INIT_VERIFY_EN
    corrupt = 1'b1;
    exec(mk(1, 0, 5'h01, 32'hFF000000, {5'h01, 15'h0}, -1));
    corrupt = 1'b0;
    ref_mem[1] = 8'hFF;
    chk("vfy_err_set", end_vfy_err, 1);
    chk("vfy_no_rd_valid", obs_vd.size(), 0);
    chk("vfy_err_sticky", bus.vfy_err, 1);
    run_vec(mk(0, 0, 5'h01, 32'hFF000000, {5'h01, 15'h0}, -1));
`endif

    // Random commands against the memory model
    for (int r = 0; r < 40; r++) begin
      rv.wr  = 1'($urandom_range(0, 1));
      rv.bst = 1'($urandom_range(0, 1));
      rv.a   = 5'($urandom_range(0, 31));
      rv.stall = (rv.wr && rv.bst && $urandom_range(0, 2) == 0) ? 2 : -1;
      for (int i = 0; i < 4; i++) begin
        rv.ea[i] = ref_addr(rv.a, i);
        rv.d[i]  = rv.wr ? 8'($urandom_range(0, 255)) : ref_mem[rv.ea[i]];
      end
      run_vec(rv);
      if (rv.wr)
        for (int i = 0; i < (rv.bst ? BL : 1); i++) ref_mem[rv.ea[i]] = rv.d[i];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
